// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// bus width, response timeout, FSM encoding and the abort read value.
package dmem_access_ctrl_pkg;

   localparam int DMEM_WIDTH   = 32;
   localparam int DMEM_TIMEOUT = 64;

   // Returned to the pipeline when a load response never arrives.
   localparam logic [31:0] DMEM_ABORT_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_word_aligned(input logic [1:0] addr_lo);
      return addr_lo == 2'b00;
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus: one valid/ready request channel plus a read-response strobe.
// The controller is the master; the memory is the slave.
interface dmem_access_ctrl_if
   import dmem_access_ctrl_pkg::*;
#(
   parameter int WIDTH = DMEM_WIDTH
) ();

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: turns one load/store into a single bus transaction,
// stalls the pipeline until it completes and hands load data to MEM/WB.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int WIDTH   = DMEM_WIDTH,
   parameter int TIMEOUT = DMEM_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memwrite_mem,
   input  logic             memtoreg_mem,
   input  logic [WIDTH-1:0] aluout_mem,
   input  logic [WIDTH-1:0] writedata_mem,
   output logic             stall,
   output logic [WIDTH-1:0] readdata_mem,
   output logic             rd_valid,
   output logic             mem_err,
   dmem_access_ctrl_if.master bus
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             access;
   logic             timeout_hit;

   assign access = memwrite_mem | memtoreg_mem;

   // Counter starts at 0 on entry to RESP, so TIMEOUT-1 marks the last waiting cycle.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

   always_comb begin
      stall = 1'b0;
      if ((state_reg == ST_IDLE && access) || state_reg == ST_REQ || state_reg == ST_RESP)
         stall = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         bus.req_valid <= 1'b0;
         bus.req_we    <= 1'b0;
         bus.req_addr  <= '0;
         bus.req_wdata <= '0;
         readdata_mem  <= '0;
         rd_valid      <= 1'b0;
         mem_err       <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (access) begin
                  if (is_word_aligned(aluout_mem[1:0])) begin
                     bus.req_valid <= 1'b1;
                     bus.req_we    <= memwrite_mem;
                     bus.req_addr  <= aluout_mem;
                     bus.req_wdata <= writedata_mem;
                     state_reg     <= ST_REQ;
                  end else begin
                     mem_err   <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_REQ: begin
               if (bus.req_ready) begin
                  bus.req_valid <= 1'b0;
                  cnt_reg       <= '0;
                  // Stores are posted: no response is awaited.
                  state_reg     <= bus.req_we ? ST_DONE : ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.resp_valid) begin
                  readdata_mem <= bus.resp_rdata;
                  rd_valid     <= 1'b1;
                  state_reg    <= ST_DONE;
               end else if (timeout_hit) begin
                  readdata_mem <= WIDTH'(DMEM_ABORT_DATA);
                  rd_valid     <= 1'b1;
                  mem_err      <= 1'b1;
                  state_reg    <= ST_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a scripted memory responder, a bus/readdata
// monitor popping expectation queues, and per-access stall/error checks.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memwrite_mem = 1'b0;
   logic        memtoreg_mem = 1'b0;
   logic [31:0] aluout_mem = '0;
   logic [31:0] writedata_mem = '0;
   logic        stall;
   logic [31:0] readdata_mem;
   logic        rd_valid;
   logic        mem_err;

   int vectors = 0;
   int miscompares = 0;

   // responder configuration (written only by the main sequence)
   int          ready_delay = 0;
   int          resp_delay = 1;
   logic        resp_enable = 1'b1;
   logic [31:0] resp_data = '0;
   int          stray_pending = 0;
   int          stray_served = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   req_t        req_q[$];
   logic [31:0] rd_q[$];

   dmem_access_ctrl_if #(.WIDTH(32)) bus ();

   dmem_access_ctrl #(.WIDTH(32), .TIMEOUT(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .memwrite_mem  (memwrite_mem),
      .memtoreg_mem  (memtoreg_mem),
      .aluout_mem    (aluout_mem),
      .writedata_mem (writedata_mem),
      .stall         (stall),
      .readdata_mem  (readdata_mem),
      .rd_valid      (rd_valid),
      .mem_err       (mem_err),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Memory model: ready after ready_delay waiting cycles, response resp_delay cycles
   // after a read handshake, plus on-demand stray responses.
   initial begin
      int wait_cnt;
      int pend;
      wait_cnt = 0;
      pend = 0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst && bus.req_valid && bus.req_ready && !bus.req_we && resp_enable)
            pend = resp_delay;
         @(posedge clk);
         #1;
         if (bus.req_valid) begin
            wait_cnt++;
            bus.req_ready = (wait_cnt > ready_delay);
         end else begin
            wait_cnt = 0;
            bus.req_ready = 1'b0;
         end
         bus.resp_valid = 1'b0;
         if (pend == 1) begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = resp_data;
            pend = 0;
         end else if (pend > 1) begin
            pend--;
         end
         if (stray_pending != stray_served) begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = 32'h5757_5757;
            stray_served++;
         end
      end
   end

   // Monitor: every handshake and every rd_valid cycle must match a queued expectation.
   initial begin
      req_t r;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus.req_valid && bus.req_ready) begin
               if (req_q.size() == 0) begin
                  check_val("unexpected_req", 32'd1, 32'd0);
               end else begin
                  r = req_q.pop_front();
                  check_val("req_we", {31'd0, bus.req_we}, {31'd0, r.we});
                  check_val("req_addr", bus.req_addr, r.addr);
                  if (r.we) check_val("req_wdata", bus.req_wdata, r.wdata);
               end
            end
            if (rd_valid) begin
               if (rd_q.size() == 0)
                  check_val("unexpected_rd_valid", 32'd1, 32'd0);
               else
                  check_val("readdata", readdata_mem, rd_q.pop_front());
            end
         end
      end
   end

   // Drive one MEM-stage access, hold it while stalled, check stall length and error flag.
   task automatic do_access(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                            input int rdy_dly, input logic [31:0] rd_exp,
                            input int exp_stall, input logic exp_err);
      int   n;
      logic aligned;
      req_t r;
      aligned = (addr[1:0] == 2'b00);
      ready_delay = rdy_dly;
      resp_data = rd_exp;
      memwrite_mem = st;
      memtoreg_mem = !st;
      aluout_mem = addr;
      writedata_mem = wdata;
      if (aligned) begin
         r.we = st;
         r.addr = addr;
         r.wdata = wdata;
         req_q.push_back(r);
         if (!st) rd_q.push_back(rd_exp);
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (!stall) break;
         n++;
         if (bus.req_valid && !bus.req_ready) begin
            check_val("hold_addr", bus.req_addr, addr);
            if (st) check_val("hold_wdata", bus.req_wdata, wdata);
         end
         if (n > 200) begin
            check_val("stall_bound", 32'd1, 32'd0);
            break;
         end
      end
      check_val("stall_cycles", n, exp_stall);
      check_val("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
      check_val("valid_dropped", {31'd0, bus.req_valid}, 32'd0);
      $display("tx %s addr=%h wdata=%h stall=%0d err=%0b rd=%h",
               st ? "store" : "load ", addr, wdata, n, mem_err, readdata_mem);
      @(posedge clk);
      #1;
      memwrite_mem = 1'b0;
      memtoreg_mem = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_stall"}, {31'd0, stall}, 32'd0);
      check_val({tag, "_req_valid"}, {31'd0, bus.req_valid}, 32'd0);
      check_val({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      check_val({tag, "_mem_err"}, {31'd0, mem_err}, 32'd0);
      check_val({tag, "_readdata"}, readdata_mem, 32'd0);
      check_val({tag, "_req_addr"}, bus.req_addr, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle_cycles(3);
      check_reset_state("reset");
      rst = 1'b1;
      idle_cycles(2);

      // 1: load, ready immediately, response one cycle later
      resp_enable = 1'b1;
      resp_delay = 1;
      do_access(1'b0, 32'h0000_0100, 32'h0, 0, 32'hCAFE_0001, 3, 1'b0);
      idle_cycles(2);

      // 2: store with ready low for 4 cycles
      do_access(1'b1, 32'h0000_0204, 32'h0000_55AA, 4, 32'h0, 6, 1'b0);
      idle_cycles(2);

      // 6: back-to-back load then store
      do_access(1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 3, 1'b0);
      do_access(1'b1, 32'h0000_0014, 32'hA5A5_0F0F, 0, 32'h0, 2, 1'b0);
      idle_cycles(2);
      check_val("readdata_held", readdata_mem, 32'h1234_5678);

      // 3: misaligned load
      do_access(1'b0, 32'h0000_0102, 32'h0, 0, 32'h0, 1, 1'b1);
      idle_cycles(2);
      check_val("err_sticky", {31'd0, mem_err}, 32'd1);

      rst = 1'b0;
      idle_cycles(1);
      check_reset_state("reset2");
      rst = 1'b1;
      idle_cycles(2);

      // 4: load with no response -> abort after 8 cycles in RESP
      resp_enable = 1'b0;
      do_access(1'b0, 32'h0000_0200, 32'h0, 0, 32'hDEAD_BEEF, 10, 1'b1);
      idle_cycles(2);

      // 5: reset while waiting in RESP, then a stray response
      ready_delay = 0;
      memtoreg_mem = 1'b1;
      aluout_mem = 32'h0000_0300;
      req_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h0});
      idle_cycles(4);
      check_val("resp_wait_stall", {31'd0, stall}, 32'd1);
      rst = 1'b0;
      memtoreg_mem = 1'b0;
      idle_cycles(1);
      check_reset_state("abort");
      rst = 1'b1;
      stray_pending++;
      idle_cycles(4);
      check_reset_state("stray");
      $display("tx abort addr=00000300 stray response injected");

      check_val("req_q_empty", req_q.size(), 32'd0);
      check_val("rd_q_empty", rd_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
